// File: rtl/launch_pkg.sv
// rtl/launch_pkg.sv - state encoding and default timing shared by the launch sequencer
package launch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHARGE = 3'd1,
    ST_READY  = 3'd2,
    ST_FIRE   = 3'd3,
    ST_DUMP   = 3'd4,
    ST_FAULT  = 3'd5
  } launch_state_t;

  localparam int unsigned CLK_HZ = 48_000_000;

  localparam int unsigned DEF_DEBOUNCE_CYC = CLK_HZ / 100;
  localparam int unsigned DEF_CHARGE_TO    = CLK_HZ * 10;
  localparam int unsigned DEF_READY_TO     = CLK_HZ * 30;
  localparam int unsigned DEF_FIRE_CYC     = CLK_HZ / 2;
  localparam int unsigned DEF_PWM_PERIOD   = 1024;
  localparam int unsigned DEF_PWM_ON       = 64;
  localparam int unsigned DEF_DUMP_CYC     = CLK_HZ * 2;
  localparam int unsigned DEF_BLINK_BIT    = 22;

  localparam int unsigned TIMER_W = 32;

  // The state timer holds at all-ones rather than wrapping back into range.
  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (&v) ? v : v + TIMER_W'(1);
  endfunction

endpackage

// File: rtl/launch_sequencer_if.sv
// rtl/launch_sequencer_if.sv - pad-side signal bundle between the board and the launch sequencer
interface launch_sequencer_if;
  import launch_pkg::*;

  logic          arm_button;
  logic          fire_button;
  logic          cont;
  logic          lt3420_done;
  logic          lt3420_charge;
  logic          pwm;
  logic          dump;
  logic          arm_led;
  logic          cont_led;
  launch_state_t state;
  logic          fault;

  modport master (
    input  arm_button, fire_button, cont, lt3420_done,
    output lt3420_charge, pwm, dump, arm_led, cont_led, state, fault
  );

  modport slave (
    output arm_button, fire_button, cont, lt3420_done,
    input  lt3420_charge, pwm, dump, arm_led, cont_led, state, fault
  );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-FF synchronizer, stability counter and press pulse for one raw button
module button_debounce
  import launch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // Any cycle where the synced input agrees with the level restarts the run.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q >= CNT_W'(DEBOUNCE_CYC - 1)) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/launch_sequencer.sv
// rtl/launch_sequencer.sv - arm/charge/fire/dump sequencer for the HV igniter path
module launch_sequencer
  import launch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned CHARGE_TO    = DEF_CHARGE_TO,
  parameter int unsigned READY_TO     = DEF_READY_TO,
  parameter int unsigned FIRE_CYC     = DEF_FIRE_CYC,
  parameter int unsigned PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int unsigned PWM_ON       = DEF_PWM_ON,
  parameter int unsigned DUMP_CYC     = DEF_DUMP_CYC,
  parameter int unsigned BLINK_BIT    = DEF_BLINK_BIT
) (
  input logic                clk,
  input logic                reset_n,
  launch_sequencer_if.master io
);

  localparam int unsigned PWM_W   = $clog2(PWM_PERIOD);
  localparam int unsigned BLINK_W = BLINK_BIT + 1;

  launch_state_t      state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic [1:0]         cont_sync_q, cont_sync_d;
  logic [1:0]         done_sync_q, done_sync_d;
  logic               charge_q, charge_d;
  logic               pwm_q, pwm_d;
  logic               dump_q, dump_d;
  logic               arm_led_q, arm_led_d;
  logic               fault_q, fault_d;

  logic arm_press;
  logic fire_press;
  logic cont_s;
  logic done_s;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arm_db (
    .clk     (clk),
    .rst_n   (reset_n),
    .btn_raw (io.arm_button),
    .press   (arm_press)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_fire_db (
    .clk     (clk),
    .rst_n   (reset_n),
    .btn_raw (io.fire_button),
    .press   (fire_press)
  );

  assign cont_s = cont_sync_q[1];
  assign done_s = done_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pwm_cnt_q   <= '0;
      blink_q     <= '0;
      cont_sync_q <= '0;
      done_sync_q <= '0;
      charge_q    <= 1'b0;
      pwm_q       <= 1'b0;
      dump_q      <= 1'b1;
      arm_led_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_q     <= blink_d;
      cont_sync_q <= cont_sync_d;
      done_sync_q <= done_sync_d;
      charge_q    <= charge_d;
      pwm_q       <= pwm_d;
      dump_q      <= dump_d;
      arm_led_q   <= arm_led_d;
      fault_q     <= fault_d;
    end
  end

  // Next state: list order inside each state is the abort priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arm_press && cont_s) state_d = ST_CHARGE;
      end
      ST_CHARGE: begin
        if (!cont_s || arm_press)             state_d = ST_DUMP;
        else if (done_s)                      state_d = ST_READY;
        else if (timer_q >= CHARGE_TO - 1)    state_d = ST_FAULT;
      end
      ST_READY: begin
        if (!cont_s || arm_press)             state_d = ST_DUMP;
        else if (fire_press)                  state_d = ST_FIRE;
        else if (timer_q >= READY_TO - 1)     state_d = ST_DUMP;
      end
      ST_FIRE: begin
        if (timer_q >= FIRE_CYC - 1) state_d = ST_DUMP;
      end
      ST_DUMP: begin
        if (timer_q >= DUMP_CYC - 1) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (arm_press) state_d = ST_IDLE;
      end
      default: state_d = ST_DUMP;
    endcase
  end

  always_comb begin
    cont_sync_d = {cont_sync_q[0], io.cont};
    done_sync_d = {done_sync_q[0], io.lt3420_done};
    blink_d     = blink_q + BLINK_W'(1);
    timer_d     = (state_d != state_q) ? '0 : sat_inc(timer_q);
    pwm_cnt_d   = '0;
    if (state_d == ST_FIRE && state_q == ST_FIRE) begin
      pwm_cnt_d = (pwm_cnt_q == PWM_W'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + PWM_W'(1);
    end
  end

  // Outputs decode from the next state so they register on the same edge as state_q.
  always_comb begin
    charge_d  = 1'b0;
    pwm_d     = 1'b0;
    dump_d    = 1'b1;
    arm_led_d = 1'b0;
    fault_d   = 1'b0;
    case (state_d)
      ST_CHARGE: begin
        charge_d  = 1'b1;
        dump_d    = 1'b0;
        arm_led_d = blink_d[BLINK_BIT];
      end
      ST_READY: begin
        charge_d  = 1'b1;
        dump_d    = 1'b0;
        arm_led_d = 1'b1;
      end
      ST_FIRE: begin
        dump_d    = 1'b0;
        arm_led_d = 1'b1;
        pwm_d     = (32'(pwm_cnt_d) < PWM_ON);
      end
      ST_FAULT: begin
        fault_d   = 1'b1;
        arm_led_d = blink_d[BLINK_BIT-2];
      end
      default: begin
      end
    endcase
  end

  assign io.lt3420_charge = charge_q;
  assign io.pwm           = pwm_q;
  assign io.dump          = dump_q;
  assign io.arm_led       = arm_led_q;
  assign io.cont_led      = cont_s;
  assign io.state         = state_q;
  assign io.fault         = fault_q;

endmodule

// File: tb/tb_launch_sequencer.sv
// tb/tb_launch_sequencer.sv - self-checking bench for launch_sequencer
module tb_launch_sequencer;
  import launch_pkg::*;

  localparam int DB  = 4;
  localparam int CTO = 100;
  localparam int RTO = 200;
  localparam int FC  = 32;
  localparam int PP  = 8;
  localparam int PO  = 2;
  localparam int DC  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  launch_sequencer_if io();

  launch_sequencer #(
    .DEBOUNCE_CYC(DB), .CHARGE_TO(CTO), .READY_TO(RTO), .FIRE_CYC(FC),
    .PWM_PERIOD(PP), .PWM_ON(PO), .DUMP_CYC(DC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: raw-sample queue for the sync delay, sample history per button,
  // and state timing tracked as the edge index at which the state was entered.
  logic [3:0]    m_q[$];
  logic [DB-1:0] m_hist[2];
  logic          m_lvl[2];
  logic          m_press[2];
  int            m_st;
  int            m_entry;
  int            m_edge;

  typedef struct {
    logic arm, fire, cont, done;
    int   cyc;
    int   st;
    logic chg, dmp, led;
    int   pwm_hi;
  } vec_t;

  vec_t tab[7];

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_q = '{4'd0, 4'd0};
    for (int b = 0; b < 2; b++) begin
      m_hist[b]  = '0;
      m_lvl[b]   = 1'b0;
      m_press[b] = 1'b0;
    end
    m_st    = 0;
    m_entry = 0;
    m_edge  = 0;
  endtask

  task automatic model_step();
    logic [3:0] raw;
    logic [3:0] syn;
    logic       sb[2];
    int         k;
    int         nxt;
    raw = {io.arm_button, io.fire_button, io.cont, io.lt3420_done};
    syn = m_q.pop_front();
    m_q.push_back(raw);
    m_edge++;
    k   = m_edge - m_entry;
    nxt = m_st;
    case (m_st)
      0: if (m_press[0] && syn[1]) nxt = 1;
      1: if (!syn[1] || m_press[0]) nxt = 4; else if (syn[0]) nxt = 2; else if (k >= CTO) nxt = 5;
      2: if (!syn[1] || m_press[0]) nxt = 4; else if (m_press[1]) nxt = 3; else if (k >= RTO) nxt = 4;
      3: if (k >= FC) nxt = 4;
      4: if (k >= DC) nxt = 0;
      5: if (m_press[0]) nxt = 0;
      default: nxt = 4;
    endcase
    if (nxt != m_st) begin
      m_st    = nxt;
      m_entry = m_edge;
    end
    sb[0] = syn[3];
    sb[1] = syn[2];
    for (int b = 0; b < 2; b++) begin
      m_hist[b]  = {m_hist[b][DB-2:0], sb[b]};
      m_press[b] = 1'b0;
      if (m_hist[b] == {DB{~m_lvl[b]}}) begin
        m_lvl[b]   = ~m_lvl[b];
        m_press[b] = m_lvl[b];
      end
    end
  endtask

  task automatic check_model(input string tag);
    int   kk;
    logic e_pwm;
    logic [5:0] want;
    logic [5:0] got;
    kk    = m_edge - m_entry;
    e_pwm = (m_st == 3) && ((kk % PP) < PO);
    want  = {(m_st == 1 || m_st == 2), e_pwm, (m_st == 0 || m_st == 4 || m_st == 5),
             (m_st == 2 || m_st == 3), m_q[0][1], (m_st == 5)};
    got   = {io.lt3420_charge, io.pwm, io.dump, io.arm_led, io.cont_led, io.fault};
    check({tag, ".state"}, int'(io.state), m_st);
    check({tag, ".outs"}, int'(got), int'(want));
    check({tag, ".pwm_dump"}, int'(io.pwm & io.dump), 0);
    check({tag, ".pwm_charge"}, int'(io.pwm & io.lt3420_charge), 0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic set_in(input logic a, input logic f, input logic c, input logic d);
    io.arm_button  = a;
    io.fire_button = f;
    io.cont        = c;
    io.lt3420_done = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_state(input int st, input int max, input string tag, output int n);
    n = 0;
    while (int'(io.state) != st && n < max) begin
      tick(tag);
      n++;
    end
    if (int'(io.state) != st) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: state got %0d want %0d after %0d cycles", tag, int'(io.state), st, n);
    end
  endtask

  task automatic go_ready(input string tag);
    int n;
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) tick(tag);
    io.arm_button = 1'b0;
    wait_state(1, 20, tag, n);
    io.lt3420_done = 1'b1;
    wait_state(2, 10, tag, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int   n;
    int   hi;
    logic seen;

    tab[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 1'b1, 1'b0, 1'b0, 0};
    tab[1] = '{1'b0, 1'b0, 1'b1, 1'b0,  5, 1, 1'b1, 1'b0, 1'b0, 0};
    tab[2] = '{1'b0, 1'b0, 1'b1, 1'b1,  4, 2, 1'b1, 1'b0, 1'b1, 0};
    tab[3] = '{1'b0, 1'b1, 1'b1, 1'b1,  6, 2, 1'b1, 1'b0, 1'b1, 0};
    tab[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32, 3, 1'b0, 1'b0, 1'b1, 8};
    tab[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 16, 4, 1'b0, 1'b1, 1'b0, 0};
    tab[6] = '{1'b0, 1'b0, 1'b1, 1'b0,  2, 0, 1'b0, 1'b1, 1'b0, 0};

    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("reset.state", int'(io.state), 0);
    check("reset.outs", int'({io.lt3420_charge, io.pwm, io.dump, io.arm_led, io.cont_led, io.fault}), 6'b001000);

    // Full arm/charge/ready/fire/dump cycle
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_in(tab[i].arm, tab[i].fire, tab[i].cont, tab[i].done);
      hi = 0;
      for (int c = 0; c < tab[i].cyc; c++) begin
        tick("seq");
        hi += int'(io.pwm);
      end
      check($sformatf("vec%0d.state", i), int'(io.state), tab[i].st);
      check($sformatf("vec%0d.charge", i), int'(io.lt3420_charge), int'(tab[i].chg));
      check($sformatf("vec%0d.dump", i), int'(io.dump), int'(tab[i].dmp));
      check($sformatf("vec%0d.arm_led", i), int'(io.arm_led), int'(tab[i].led));
      check($sformatf("vec%0d.pwm_high", i), hi, tab[i].pwm_hi);
    end

    // Charge timeout into FAULT, arm press recovers
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) tick("fault");
    io.arm_button = 1'b0;
    wait_state(1, 20, "fault", n);
    n = 0;
    while (int'(io.state) == 1 && n < 200) begin
      tick("fault");
      n++;
    end
    check("fault.charge_cycles", n, CTO);
    check("fault.state", int'(io.state), 5);
    check("fault.flags", int'({io.fault, io.dump, io.lt3420_charge}), 3'b110);
    io.arm_button = 1'b1;
    repeat (6) tick("fault");
    io.arm_button = 1'b0;
    wait_state(0, 10, "fault_exit", n);
    check("fault_exit.fault", int'(io.fault), 0);

    // Continuity loss in READY, then arm without continuity in IDLE
    go_ready("cont");
    io.cont = 1'b0;
    wait_state(4, 10, "cont", n);
    check("cont.dump_latency", n, 3);
    wait_state(0, 40, "cont", n);
    io.arm_button = 1'b1;
    repeat (6) tick("nocont");
    io.arm_button = 1'b0;
    repeat (10) tick("nocont");
    check("nocont.state", int'(io.state), 0);

    // Simultaneous arm and fire in READY
    go_ready("both");
    io.arm_button  = 1'b1;
    io.fire_button = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick("both");
      seen |= io.pwm;
    end
    io.arm_button  = 1'b0;
    io.fire_button = 1'b0;
    check("both.state", int'(io.state), 4);
    repeat (20) begin
      tick("both");
      seen |= io.pwm;
    end
    check("both.pwm_seen", int'(seen), 0);

    // Glitch rejection and the minimum accepted press, all in READY
    go_ready("glitch");
    io.arm_button = 1'b1;
    repeat (3) tick("glitch");
    io.arm_button = 1'b0;
    repeat (8) tick("glitch");
    check("glitch.arm3", int'(io.state), 2);
    for (int t = 0; t < 10; t++) begin
      io.fire_button = ~io.fire_button;
      repeat (2) tick("chatter");
    end
    io.fire_button = 1'b0;
    repeat (6) tick("chatter");
    check("chatter.state", int'(io.state), 2);
    io.arm_button = 1'b1;
    repeat (4) tick("arm4");
    io.arm_button = 1'b0;
    wait_state(4, 10, "arm4", n);
    check("arm4.state", int'(io.state), 4);

    // Asynchronous reset in the middle of FIRE
    go_ready("arst");
    io.fire_button = 1'b1;
    repeat (6) tick("arst");
    io.fire_button = 1'b0;
    wait_state(3, 10, "arst", n);
    check("arst.pwm_before", int'(io.pwm), 1);
    reset_n = 1'b0;
    #1;
    check("arst.pwm", int'(io.pwm), 0);
    check("arst.dump", int'(io.dump), 1);
    check("arst.state", int'(io.state), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    tick("arst");
    check("arst.after", int'(io.state), 0);

    // Random button stress against the model
    do_reset();
    for (int s = 0; s < 400; s++) begin
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(1, 10)) tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
